game_command_gen: RTL and testbench
===================================

GAME_COMMAND_GEN -- requirements
Module: game_command_gen

Interface
REQ-001 Parameter gravity_period_p, default 50000000, clock cycles between automatic eMoveDown requests; SHALL be >= 2.
REQ-002 Parameter fifo_depth_p, default 4, opcode FIFO entries; SHALL be a power of 2, >= 2.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  start-game pulse.
REQ-006 btn_left_i, btn_right_i, btn_down_i, btn_rotate_i  input  1 each  raw push buttons, asynchronous to clk_i.
REQ-007 landed_i  input  1  pulse from the game plate: the current tile cannot move down.
REQ-008 lose_i  input  1  level from the game plate: game lost.
REQ-009 opcode_o  output  opcode_e  head of the FIFO; valid only while opcode_empty_o = 0.
REQ-010 opcode_empty_o  output  1  FIFO empty.
REQ-011 opcode_read_i  input  1  pop request from the game plate.
REQ-012 running_o  output  1  high in state eRun.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized level sets that source's sticky pending flag.
REQ-014 A pending flag SHALL clear only on the cycle its opcode is pushed; a repeat event while pending SHALL be absorbed, with no second request.
REQ-015 The soft-drop button and gravity expiry SHALL share one down-pending flag.
REQ-016 States: eIdle, eRun, eLandCommit, eLandCheck, eLandNew, eHalt; reset enters eIdle.
REQ-017 eIdle: on start_i, push eNew if the FIFO is not full and go to eRun; otherwise hold.
REQ-018 eRun: on landed_i go to eLandCommit, even with flags pending.
REQ-019 eRun, FIFO not full: push at most one opcode per cycle, priority rotate > left > right > down.
REQ-020 eLandCommit, eLandCheck, eLandNew: each pushes eCommit, eCheck, eNew respectively when the FIFO is not full, then advances; eLandNew returns to eRun.
REQ-021 Pending flags SHALL be held, not cleared, during eLand* states.
REQ-022 Gravity counter: cleared on entering eRun; increments in eRun only; at gravity_period_p-1 it sets down-pending and wraps to 0.
REQ-023 lose_i high in any state SHALL take priority over all else: next state eHalt, FIFO flushed, all pending flags and the gravity counter cleared, and no push that cycle.
REQ-024 eHalt: no pushes, buttons ignored; start_i with lose_i low goes to eIdle behaviour, pushing eNew and entering eRun.
REQ-025 FIFO is first-word fall-through with a registered count of $clog2(fifo_depth_p)+1 bits and read/write pointers that wrap modulo fifo_depth_p.
REQ-026 Pop SHALL occur when opcode_read_i && !opcode_empty_o; a pop request while empty SHALL be ignored.
REQ-027 Push is gated by the registered full flag; simultaneous push and pop when non-empty and non-full leaves the count unchanged.
REQ-028 Latency: a push is visible on opcode_o/opcode_empty_o the cycle after the push edge; a button edge reaches the FIFO at least 3 cycles after the input change.

Reset
REQ-029 Reset asserted SHALL immediately, asynchronously, set: state eIdle, FIFO empty (opcode_empty_o = 1), pointers and count 0, flags, synchronizers and gravity counter 0, running_o = 0.
REQ-030 While reset is asserted, opcode_o SHALL be eNew (encoding 0 of the FIFO storage reset).
REQ-031 Reset mid-sequence, including in eLand*, SHALL discard all queued and pending work.

Structure
REQ-032 opcode_e, and the state enum game_cmd_state_e, SHALL live in package tetris; no new constants beyond the parameters.
REQ-033 The FIFO SHALL be a sub-module opcode_fifo (parameters width and depth, push/pop/full/empty); all other logic stays in game_command_gen.

Verification
REQ-034 Reset, then start_i pulse -> eNew at the head next cycle, running_o = 1.
REQ-035 gravity_period_p = 8, no pops after start -> eMoveDown pushed every 8 cycles; the FIFO fills at 4 entries, then further expiries absorb into one pending flag.
REQ-036 Rotate and left edges in the same cycle, FIFO not full -> eRotate, then eMoveLeft on consecutive pushes.
REQ-037 landed_i while the left flag is pending -> FIFO order eCommit, eCheck, eNew, eMoveLeft.
REQ-038 lose_i with 3 entries queued -> opcode_empty_o = 1 next cycle; button presses then ignored; start_i -> eNew.
REQ-039 reset_n_i low in eLandCheck with the FIFO partly full -> empty and eIdle asynchronously; no stale opcode appears after release.

Source files
------------

// File: rtl/game_command_gen_pkg.sv
// Shared types for the game command generator.
//   opcode_e         : commands handed to the game plate through the opcode FIFO.
//   game_cmd_state_e : sequencing states of game_command_gen.
package tetris;

  // eNew must stay at encoding 0: the FIFO storage resets to zero, so the
  // head reads eNew while reset is held.
  typedef enum logic [2:0] {
    eNew       = 3'd0,
    eMoveLeft  = 3'd1,
    eMoveRight = 3'd2,
    eMoveDown  = 3'd3,
    eRotate    = 3'd4,
    eCommit    = 3'd5,
    eCheck     = 3'd6
  } opcode_e;

  typedef enum logic [2:0] {
    eIdle       = 3'd0,
    eRun        = 3'd1,
    eLandCommit = 3'd2,
    eLandCheck  = 3'd3,
    eLandNew    = 3'd4,
    eHalt       = 3'd5
  } game_cmd_state_e;

endpackage

// File: rtl/game_command_gen_opcode_fifo.sv
// opcode_fifo: first-word fall-through FIFO with a registered occupancy count.
//   clk_i, reset_n_i : clock, async active-low reset (storage cleared to 0)
//   flush_i          : drop all entries; wins over push and pop
//   push_i, data_i   : write, ignored while full
//   pop_i            : read, ignored while empty
//   data_o           : current head (valid while empty_o = 0)
//   full_o, empty_o  : decoded from the registered count
module opcode_fifo #(
  parameter int width_p = 3,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int aw = $clog2(depth_p);
  localparam int cw = aw + 1;

  logic [width_p-1:0] mem [depth_p];
  logic [aw-1:0]      wr_ptr, rd_ptr;
  logic [cw-1:0]      count;
  logic               do_push, do_pop;

  assign full_o  = (count == cw'(depth_p));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem <= '{default: '0};
    end else if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally since depth_p is a power of two.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + aw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/game_command_gen.sv
// game_command_gen: turns buttons, gravity and plate events into an opcode stream.
//   clk_i, reset_n_i         : clock, async active-low reset
//   start_i                  : start a game (from idle or halted)
//   btn_*_i                  : raw asynchronous push buttons
//   landed_i                 : tile landed -> commit / check / new sequence
//   lose_i                   : game lost; flushes everything and halts
//   opcode_o, opcode_empty_o : FIFO head and empty flag
//   opcode_read_i            : pop request from the plate
//   running_o                : high in eRun
module game_command_gen
  import tetris::*;
#(
  parameter int gravity_period_p = 50000000,
  parameter int fifo_depth_p     = 4
) (
  input  logic    clk_i,
  input  logic    reset_n_i,
  input  logic    start_i,
  input  logic    btn_left_i,
  input  logic    btn_right_i,
  input  logic    btn_down_i,
  input  logic    btn_rotate_i,
  input  logic    landed_i,
  input  logic    lose_i,
  output opcode_e opcode_o,
  input  logic    opcode_read_i,
  output logic    opcode_empty_o,
  output logic    running_o
);

  localparam int grav_w = $clog2(gravity_period_p);
  localparam int op_w   = $bits(opcode_e);

  game_cmd_state_e state, state_n;

  // Button vectors, bit order: [3] rotate, [2] left, [1] right, [0] down.
  // The order doubles as push priority (highest bit wins).
  logic [3:0] btn_raw, sync_q1, sync_q2, btn_prev, btn_rise;
  logic [3:0] pend, pend_set, pend_clr;

  logic [grav_w-1:0] grav_cnt;
  logic              grav_hit, enter_run;

  logic              push, fifo_full;
  opcode_e           push_op;
  logic [op_w-1:0]   head;

  assign btn_raw  = {btn_rotate_i, btn_left_i, btn_right_i, btn_down_i};
  assign btn_rise = sync_q2 & ~btn_prev;

  // sync_q1/sync_q2 form the synchronizer; btn_prev only feeds edge detect.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      btn_prev <= '0;
    end else begin
      sync_q1  <= btn_raw;
      sync_q2  <= sync_q1;
      btn_prev <= sync_q2;
    end
  end

  // Gravity and soft-drop share the down flag, so an expiry while down is
  // already pending is simply absorbed.
  assign grav_hit = (state == eRun) && (grav_cnt == grav_w'(gravity_period_p - 1));
  assign pend_set = (state == eHalt) ? 4'b0 : (btn_rise | {3'b000, grav_hit});

  // A flag being pushed this cycle clears even if a fresh edge arrives now:
  // that edge counts as a repeat while still pending.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  pend <= '0;
    else if (lose_i) pend <= '0;
    else             pend <= (pend | pend_set) & ~pend_clr;
  end

  assign enter_run = (state_n == eRun) && (state != eRun);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                 grav_cnt <= '0;
    else if (lose_i || enter_run)   grav_cnt <= '0;
    else if (grav_hit)              grav_cnt <= '0;
    else if (state == eRun)         grav_cnt <= grav_cnt + grav_w'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= eIdle;
    else            state <= state_n;
  end

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    push_op  = eNew;
    pend_clr = '0;
    if (lose_i) begin
      state_n = eHalt;
    end else begin
      case (state)
        eIdle, eHalt: begin
          if (start_i && !fifo_full) begin
            push    = 1'b1;
            push_op = eNew;
            state_n = eRun;
          end
        end
        eRun: begin
          // Landing wins over pending moves; they stay queued in the flags.
          if (landed_i) begin
            state_n = eLandCommit;
          end else if (!fifo_full) begin
            if (pend[3]) begin
              push = 1'b1; push_op = eRotate;    pend_clr[3] = 1'b1;
            end else if (pend[2]) begin
              push = 1'b1; push_op = eMoveLeft;  pend_clr[2] = 1'b1;
            end else if (pend[1]) begin
              push = 1'b1; push_op = eMoveRight; pend_clr[1] = 1'b1;
            end else if (pend[0]) begin
              push = 1'b1; push_op = eMoveDown;  pend_clr[0] = 1'b1;
            end
          end
        end
        eLandCommit: begin
          if (!fifo_full) begin
            push = 1'b1; push_op = eCommit; state_n = eLandCheck;
          end
        end
        eLandCheck: begin
          if (!fifo_full) begin
            push = 1'b1; push_op = eCheck; state_n = eLandNew;
          end
        end
        eLandNew: begin
          if (!fifo_full) begin
            push = 1'b1; push_op = eNew; state_n = eRun;
          end
        end
        default: state_n = eIdle;
      endcase
    end
  end

  opcode_fifo #(
    .width_p (op_w),
    .depth_p (fifo_depth_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (lose_i),
    .push_i    (push),
    .data_i    (push_op),
    .pop_i     (opcode_read_i),
    .data_o    (head),
    .full_o    (fifo_full),
    .empty_o   (opcode_empty_o)
  );

  assign opcode_o  = opcode_e'(head);
  assign running_o = (state == eRun);

endmodule

// File: tb/tb_game_command_gen.sv
module tb_game_command_gen;
  import tetris::*;

  localparam int P = 8;
  localparam int D = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAND = 2, M_HALT = 3;

  logic clk_i = 1'b0, reset_n_i = 1'b0, start_i = 1'b0;
  logic btn_left_i = 1'b0, btn_right_i = 1'b0, btn_down_i = 1'b0, btn_rotate_i = 1'b0;
  logic landed_i = 1'b0, lose_i = 1'b0, opcode_read_i = 1'b0;
  opcode_e opcode_o;
  logic opcode_empty_o, running_o;

  always #5 clk_i = ~clk_i;

  game_command_gen #(.gravity_period_p(P), .fifo_depth_p(D)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .btn_left_i(btn_left_i), .btn_right_i(btn_right_i),
    .btn_down_i(btn_down_i), .btn_rotate_i(btn_rotate_i),
    .landed_i(landed_i), .lose_i(lose_i),
    .opcode_o(opcode_o), .opcode_read_i(opcode_read_i),
    .opcode_empty_o(opcode_empty_o), .running_o(running_o)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: game mode, a queue for the FIFO, a queue for the
  // remaining landing commands, pending-request bits and a gravity tick count.
  // Button samples at the last three clock edges model sync + edge detect.
  int         mode;
  opcode_e    q[$];
  opcode_e    land_q[$];
  logic [3:0] pend, h1, h2, h3;
  int         grav;

  function automatic opcode_e btn_op(input int i);
    case (i)
      3:       return eRotate;
      2:       return eMoveLeft;
      1:       return eMoveRight;
      default: return eMoveDown;
    endcase
  endfunction

  task automatic model_reset();
    mode = M_IDLE; q.delete(); land_q.delete();
    pend = '0; h1 = '0; h2 = '0; h3 = '0; grav = 0;
  endtask

  task automatic model_step();
    logic [3:0] cur, rise, set, clr;
    bit full, do_pop, do_push, halted, expired;
    opcode_e op;
    cur  = {btn_rotate_i, btn_left_i, btn_right_i, btn_down_i};
    rise = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = cur;
    full    = (q.size() >= D);
    do_pop  = opcode_read_i && (q.size() > 0);
    do_push = 0; op = eNew; clr = '0; expired = 0;
    halted  = (mode == M_HALT);
    if (lose_i) begin
      q.delete(); land_q.delete(); pend = '0; grav = 0; mode = M_HALT;
      return;
    end
    case (mode)
      M_IDLE, M_HALT: begin
        if (start_i && !full) begin
          op = eNew; do_push = 1; mode = M_RUN; grav = 0;
        end
      end
      M_RUN: begin
        expired = (grav == P - 1);
        grav = expired ? 0 : grav + 1;
        if (landed_i) begin
          mode = M_LAND;
          land_q.push_back(eCommit); land_q.push_back(eCheck); land_q.push_back(eNew);
        end else if (!full) begin
          for (int i = 3; i >= 0; i--)
            if (!do_push && pend[i]) begin
              do_push = 1; op = btn_op(i); clr[i] = 1'b1;
            end
        end
      end
      default: begin
        if (!full) begin
          op = land_q.pop_front(); do_push = 1;
          if (land_q.size() == 0) begin mode = M_RUN; grav = 0; end
        end
      end
    endcase
    set  = halted ? 4'b0 : (rise | {3'b000, expired});
    pend = (pend | set) & ~clr;
    if (do_pop)  q.delete(0);
    if (do_push) q.push_back(op);
  endtask

  task automatic compare();
    chk("empty", opcode_empty_o, q.size() == 0);
    if (q.size() != 0) chk("head", opcode_o, q[0]);
    chk("running", running_o, mode == M_RUN);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      if (reset_n_i) model_step();
      @(negedge clk_i);
      compare();
    end
  endtask

  task automatic pulse(input int which);
    case (which)
      0: start_i = 1'b1;
      1: landed_i = 1'b1;
      default: lose_i = 1'b1;
    endcase
    step();
    start_i = 1'b0; landed_i = 1'b0; lose_i = 1'b0;
  endtask

  // Asserts reset between edges and checks the asynchronous effect at once.
  task automatic do_reset();
    start_i = 0; landed_i = 0; lose_i = 0; opcode_read_i = 0;
    #2 reset_n_i = 1'b0;
    #1;
    model_reset();
    chk("rst_empty", opcode_empty_o, 1);
    chk("rst_running", running_o, 0);
    chk("rst_head", opcode_o, eNew);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    do_reset();
    step(2);

    // Start: eNew at head the next cycle.
    pulse(0);
    chk("start_head", opcode_o, eNew);
    chk("start_running", running_o, 1);

    // Gravity with no pops: fills at D entries, further expiries absorbed.
    step(40);
    chk("fill_head", opcode_o, eNew);
    chk("fill_nonempty", opcode_empty_o, 0);
    opcode_read_i = 1; step(6); opcode_read_i = 0;

    // Rotate and left in the same cycle.
    btn_rotate_i = 1; btn_left_i = 1;
    step(6);
    btn_rotate_i = 0; btn_left_i = 0;
    step(3);
    opcode_read_i = 1; step(8); opcode_read_i = 0;

    // Landed while left pending: commit, check, new, then left.
    btn_left_i = 1; step(3);
    pulse(1);
    btn_left_i = 0;
    step(8);

    // Lose with entries queued: flush, ignore buttons, restart.
    pulse(2);
    chk("lose_empty", opcode_empty_o, 1);
    chk("lose_running", running_o, 0);
    btn_right_i = 1; btn_down_i = 1; step(5);
    btn_right_i = 0; btn_down_i = 0; step(5);
    chk("halt_still_empty", opcode_empty_o, 1);
    pulse(0);
    chk("restart_head", opcode_o, eNew);
    chk("restart_running", running_o, 1);

    // Reset while in the landing sequence with entries queued.
    opcode_read_i = 1; step(6); opcode_read_i = 0;
    pulse(1);
    step();
    do_reset();
    step(12);
    chk("post_rst_empty", opcode_empty_o, 1);
    pulse(0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) btn_rotate_i = ~btn_rotate_i;
      if ($urandom_range(5) == 0) btn_left_i   = ~btn_left_i;
      if ($urandom_range(5) == 0) btn_right_i  = ~btn_right_i;
      if ($urandom_range(5) == 0) btn_down_i   = ~btn_down_i;
      start_i       = ($urandom_range(9) == 0);
      landed_i      = ($urandom_range(11) == 0);
      lose_i        = ($urandom_range(59) == 0);
      opcode_read_i = ($urandom_range(2) == 0);
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end
    start_i = 0; landed_i = 0; lose_i = 0; opcode_read_i = 0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
